// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and count helpers. The top-level
// timing generator and downstream consumers (block_controller, ROM lookup)
// take their default geometry and display-area bounds from here.
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    // Default 640x480@60 geometry with a 25 MHz pixel rate from a 100 MHz clock.
    localparam int VGA_CLK_DIV = 4;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_TOTAL = 525;

    // Inclusive bounds of the visible area for the default geometry.
    localparam int H_DISP_START = VGA_H_SYNC + VGA_H_BP;            // 144
    localparam int H_DISP_END   = H_DISP_START + VGA_H_DISP - 1;    // 783
    localparam int V_DISP_START = VGA_V_SYNC + VGA_V_BP;            // 35
    localparam int V_DISP_END   = V_DISP_START + VGA_V_DISP - 1;    // 514

    typedef logic [COUNT_W-1:0] count_t;

    // Inclusive range test on a pixel or line count.
    function automatic logic in_range(input count_t val, input count_t lo, input count_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Clock-enable divider: emits a registered one-cycle pulse every CLK_DIV
// clocks. After reset is released the first pulse appears exactly CLK_DIV
// clocks later. CLK_DIV must be at least 2.
module clk_en_divider
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic en_out
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo-CLK_DIV count; the pulse is registered one cycle
    // after the count reaches its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            en_out <= 1'b0;
        end else begin
            en_out <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, horizontal/vertical counters,
// active-low sync pulses, display-area flag and a one-clock frame tick.
// Decoded outputs are computed from the next counter values so every
// registered output lines up with the hCount/vCount it belongs to.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int H_DISP  = VGA_H_DISP,
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP,
    parameter int V_DISP  = VGA_V_DISP,
    parameter int V_TOTAL = VGA_V_TOTAL
) (
    input  logic         clk,
    input  logic         rst,
    output logic         pix_en,
    output logic [9:0]   hCount,
    output logic [9:0]   vCount,
    output logic         hSync,
    output logic         vSync,
    output logic         bright,
    output logic         frame_tick
);

    localparam count_t CNT_ONE   = count_t'(1);
    localparam count_t H_LAST    = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST    = count_t'(V_TOTAL - 1);
    localparam count_t H_SYNC_W  = count_t'(H_SYNC);
    localparam count_t V_SYNC_W  = count_t'(V_SYNC);
    localparam count_t H_VIS_LO  = count_t'(H_SYNC + H_BP);
    localparam count_t H_VIS_HI  = count_t'(H_SYNC + H_BP + H_DISP - 1);
    localparam count_t V_VIS_LO  = count_t'(V_SYNC + V_BP);
    localparam count_t V_VIS_HI  = count_t'(V_SYNC + V_BP + V_DISP - 1);

    count_t h_nxt;
    count_t v_nxt;
    logic   wrap_nxt;
    logic   hsync_nxt;
    logic   vsync_nxt;
    logic   bright_nxt;

    clk_en_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_out (pix_en)
    );

    // Next counter values: advance only on a pixel enable, carry into the
    // line counter at end of line, flag the full-frame wrap.
    always_comb begin
        h_nxt    = hCount;
        v_nxt    = vCount;
        wrap_nxt = 1'b0;
        if (pix_en) begin
            if (hCount == H_LAST) begin
                h_nxt = '0;
                if (vCount == V_LAST) begin
                    v_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    v_nxt = vCount + CNT_ONE;
                end
            end else begin
                h_nxt = hCount + CNT_ONE;
            end
        end
    end

    // Sync and display-area decode from the next counts (syncs are active low).
    always_comb begin
        hsync_nxt  = !(h_nxt < H_SYNC_W);
        vsync_nxt  = !(v_nxt < V_SYNC_W);
        bright_nxt = in_range(h_nxt, H_VIS_LO, H_VIS_HI) &&
                     in_range(v_nxt, V_VIS_LO, V_VIS_HI);
    end

    // Output registers; reset drops any pending frame tick and restarts at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            hSync      <= hsync_nxt;
            vSync      <= vsync_nxt;
            bright     <= bright_nxt;
            frame_tick <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. One instance uses the default 640x480 geometry
// (reset and line timing); a second uses CLK_DIV=2 and a tiny 20x14 frame
// (visible h 7..16, v 5..10) so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_s;

    logic       pix_en, hsync, vsync, bright, frame_tick;
    logic [9:0] h_count, v_count;
    logic       pix_en_s, hsync_s, vsync_s, bright_s, frame_tick_s;
    logic [9:0] h_count_s, v_count_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hCount     (h_count),
        .vCount     (v_count),
        .hSync      (hsync),
        .vSync      (vsync),
        .bright     (bright),
        .frame_tick (frame_tick)
    );

    vga_sync_gen #(
        .CLK_DIV (2),
        .H_SYNC  (4),
        .H_BP    (3),
        .H_DISP  (10),
        .H_TOTAL (20),
        .V_SYNC  (2),
        .V_BP    (3),
        .V_DISP  (6),
        .V_TOTAL (14)
    ) u_small (
        .clk        (clk),
        .rst        (rst_s),
        .pix_en     (pix_en_s),
        .hCount     (h_count_s),
        .vCount     (v_count_s),
        .hSync      (hsync_s),
        .vSync      (vsync_s),
        .bright     (bright_s),
        .frame_tick (frame_tick_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int k;
        rst   = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({pix_en, h_count, v_count, hsync, vsync, bright, frame_tick} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got en=%b h=%0d v=%0d hs=%b vs=%b br=%b ft=%b, want all 0",
                         i, pix_en, h_count, v_count, hsync, vsync, bright, frame_tick);
            end
            n_tests++;
            if ({pix_en_s, h_count_s, v_count_s, hsync_s, vsync_s, bright_s, frame_tick_s} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_outputs_small cyc %0d: got en=%b h=%0d v=%0d, want all 0",
                         i, pix_en_s, h_count_s, v_count_s);
            end
        end
        rst = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!pix_en && k < 20);
        n_tests++;
        if (k !== 4) begin
            n_fail++;
            $display("FAIL first_pix_en: got %0d clks after release, want 4", k);
        end
        n_tests++;
        if (h_count !== 10'd0 || v_count !== 10'd0) begin
            n_fail++;
            $display("FAIL first_pix_en_count: got (%0d,%0d), want (0,0)", h_count, v_count);
        end
        for (int p = 0; p < 3; p++) begin
            k = 0;
            do begin
                tick();
                k++;
            end while (!pix_en && k < 20);
            n_tests++;
            if (k !== 4) begin
                n_fail++;
                $display("FAIL pix_en_period %0d: got %0d clks, want 4", p, k);
            end
        end
    endtask

    // Entered on the sample of the fourth pix_en after release, where h=3, v=0.
    task automatic test_horizontal();
        int h_m, v_m, phase, seq_err, v1_hs_clks, v1_hs_pix, v1_clks, v_changes, v_bad, max_h, br_seen;
        logic en_m, en_prev;
        int prev_h, prev_v;
        h_m = 3; v_m = 0; phase = 0; en_prev = 1'b1;
        seq_err = 0; v1_hs_clks = 0; v1_hs_pix = 0; v1_clks = 0;
        v_changes = 0; v_bad = 0; max_h = 0; br_seen = 0;
        prev_h = 3; prev_v = 0;
        for (int i = 0; i < 6500; i++) begin
            tick();
            if (en_prev) begin
                if (h_m == 799) begin
                    h_m = 0;
                    v_m = v_m + 1;
                end else begin
                    h_m = h_m + 1;
                end
            end
            phase = (phase + 1) % 4;
            en_m  = (phase == 0);
            en_prev = en_m;
            if (pix_en !== en_m || int'(h_count) != h_m || int'(v_count) != v_m ||
                hsync !== (h_m >= 96) || vsync !== (v_m >= 2)) begin
                if (seq_err == 0)
                    $display("FAIL h_sequence at i=%0d: got en=%b h=%0d v=%0d hs=%b vs=%b, want en=%b h=%0d v=%0d",
                             i, pix_en, h_count, v_count, hsync, vsync, en_m, h_m, v_m);
                seq_err++;
            end
            if (v_count == 10'd1) begin
                v1_clks++;
                if (!hsync) v1_hs_clks++;
                if (!hsync && pix_en) v1_hs_pix++;
            end
            if (int'(v_count) != prev_v) begin
                v_changes++;
                if (prev_h != 799 || h_count != 10'd0) v_bad++;
            end
            if (int'(h_count) > max_h) max_h = int'(h_count);
            if (bright || frame_tick) br_seen++;
            prev_h = int'(h_count);
            prev_v = int'(v_count);
        end
        n_tests++;
        if (seq_err != 0) begin
            n_fail++;
            $display("FAIL h_sequence_total: got %0d bad cycles, want 0", seq_err);
        end
        n_tests++;
        if (v1_hs_clks != 384) begin
            n_fail++;
            $display("FAIL hsync_low_clks: got %0d, want 384", v1_hs_clks);
        end
        n_tests++;
        if (v1_hs_pix != 96) begin
            n_fail++;
            $display("FAIL hsync_low_pix: got %0d, want 96", v1_hs_pix);
        end
        n_tests++;
        if (v1_clks != 3200) begin
            n_fail++;
            $display("FAIL line_clks: got %0d, want 3200", v1_clks);
        end
        n_tests++;
        if (v_changes != 2 || v_bad != 0) begin
            n_fail++;
            $display("FAIL v_increment: got %0d changes (%0d off-wrap), want 2 (0)", v_changes, v_bad);
        end
        n_tests++;
        if (max_h != 799) begin
            n_fail++;
            $display("FAIL h_max: got %0d, want 799", max_h);
        end
        n_tests++;
        if (br_seen != 0) begin
            n_fail++;
            $display("FAIL top_lines_dark: got %0d bright/frame_tick cycles, want 0", br_seen);
        end
    endtask

    // Small instance, one frame from reset release. The wrap happens on the
    // edge where the 280th pix_en is consumed: clock 2*280+1 = 561.
    task automatic test_display_window();
        int cyc, first_en, ft_cyc, fh, fv, lh, lv, br_pix, viol;
        logic found;
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        cyc = 0; first_en = 0; ft_cyc = 0; found = 1'b0;
        fh = -1; fv = -1; lh = -1; lv = -1; br_pix = 0; viol = 0;
        while (cyc < 2000) begin
            tick();
            cyc++;
            if (pix_en_s && first_en == 0) first_en = cyc;
            if (bright_s && !found) begin
                found = 1'b1;
                fh = int'(h_count_s);
                fv = int'(v_count_s);
            end
            if (bright_s) begin
                lh = int'(h_count_s);
                lv = int'(v_count_s);
            end
            if (bright_s && pix_en_s) br_pix++;
            if (bright_s && (!hsync_s || !vsync_s)) viol++;
            if (frame_tick_s) begin
                ft_cyc = cyc;
                break;
            end
        end
        n_tests++;
        if (first_en != 2) begin
            n_fail++;
            $display("FAIL small_first_pix_en: got %0d, want 2", first_en);
        end
        n_tests++;
        if (fh != 7 || fv != 5) begin
            n_fail++;
            $display("FAIL bright_first: got (%0d,%0d), want (7,5)", fh, fv);
        end
        n_tests++;
        if (lh != 16 || lv != 10) begin
            n_fail++;
            $display("FAIL bright_last: got (%0d,%0d), want (16,10)", lh, lv);
        end
        n_tests++;
        if (br_pix != 60) begin
            n_fail++;
            $display("FAIL bright_count: got %0d, want 60", br_pix);
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL bright_in_sync: got %0d cycles, want 0", viol);
        end
        n_tests++;
        if (ft_cyc != 561) begin
            n_fail++;
            $display("FAIL first_frame_tick: got clk %0d, want 561", ft_cyc);
        end
        n_tests++;
        if (h_count_s !== 10'd0 || v_count_s !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap_counts: got (%0d,%0d), want (0,0)", h_count_s, v_count_s);
        end
    endtask

    // Entered on a frame_tick sample; checks three further ticks.
    task automatic test_frame_tick();
        int cyc, vs_pix, ph, pv;
        for (int f = 0; f < 3; f++) begin
            tick();
            n_tests++;
            if (frame_tick_s !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_tick_width %0d: got %b one clk after tick, want 0", f, frame_tick_s);
            end
            cyc = 1; vs_pix = 0; ph = int'(h_count_s); pv = int'(v_count_s);
            while (!frame_tick_s && cyc < 2000) begin
                if (pix_en_s && !vsync_s) vs_pix++;
                ph = int'(h_count_s);
                pv = int'(v_count_s);
                tick();
                cyc++;
            end
            n_tests++;
            if (cyc != 560) begin
                n_fail++;
                $display("FAIL frame_tick_spacing %0d: got %0d clks, want 560", f, cyc);
            end
            n_tests++;
            if (ph != 19 || pv != 13 || h_count_s !== 10'd0 || v_count_s !== 10'd0) begin
                n_fail++;
                $display("FAIL frame_tick_wrap %0d: got (%0d,%0d)->(%0d,%0d), want (19,13)->(0,0)",
                         f, ph, pv, h_count_s, v_count_s);
            end
            n_tests++;
            if (vs_pix != 40) begin
                n_fail++;
                $display("FAIL vsync_low_pix %0d: got %0d, want 40", f, vs_pix);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int cyc, first_en, line_cyc, ft_cyc, ph;
        cyc = 0;
        while (!(h_count_s == 10'd12 && v_count_s == 10'd8) && cyc < 2000) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL reach_mid_frame: got timeout, want (12,8)");
        end
        rst_s = 1'b1;
        tick();
        n_tests++;
        if ({pix_en_s, h_count_s, v_count_s, hsync_s, vsync_s, bright_s, frame_tick_s} !== 25'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got en=%b h=%0d v=%0d br=%b ft=%b, want all 0",
                     pix_en_s, h_count_s, v_count_s, bright_s, frame_tick_s);
        end
        rst_s = 1'b0;
        cyc = 0; first_en = 0; line_cyc = 0; ft_cyc = 0; ph = 0;
        while (ft_cyc == 0 && cyc < 2000) begin
            ph = int'(h_count_s);
            tick();
            cyc++;
            if (pix_en_s && first_en == 0) first_en = cyc;
            if (v_count_s == 10'd1 && line_cyc == 0) begin
                line_cyc = cyc;
                n_tests++;
                if (ph != 19 || h_count_s !== 10'd0) begin
                    n_fail++;
                    $display("FAIL restart_line_wrap: got h %0d->%0d, want 19->0", ph, h_count_s);
                end
            end
            if (frame_tick_s) ft_cyc = cyc;
        end
        n_tests++;
        if (first_en != 2) begin
            n_fail++;
            $display("FAIL restart_first_pix_en: got %0d, want 2", first_en);
        end
        n_tests++;
        if (line_cyc != 41) begin
            n_fail++;
            $display("FAIL restart_first_line: got clk %0d, want 41", line_cyc);
        end
        n_tests++;
        if (ft_cyc != 561) begin
            n_fail++;
            $display("FAIL restart_frame_tick: got clk %0d, want 561", ft_cyc);
        end
        // Reset on the very cycle a frame wrap is pending must swallow the tick.
        cyc = 0;
        while (!(h_count_s == 10'd19 && v_count_s == 10'd13 && pix_en_s) && cyc < 2000) begin
            tick();
            cyc++;
        end
        rst_s = 1'b1;
        tick();
        n_tests++;
        if (frame_tick_s !== 1'b0 || h_count_s !== 10'd0 || v_count_s !== 10'd0 || cyc >= 2000) begin
            n_fail++;
            $display("FAIL pending_tick_drop: got ft=%b (%0d,%0d) wait=%0d, want ft=0 (0,0)",
                     frame_tick_s, h_count_s, v_count_s, cyc);
        end
        rst_s = 1'b0;
        tick();
        n_tests++;
        if (frame_tick_s !== 1'b0 || pix_en_s !== 1'b0) begin
            n_fail++;
            $display("FAIL post_drop_quiet: got ft=%b en=%b, want 0 0", frame_tick_s, pix_en_s);
        end
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_horizontal();
        test_display_window();
        test_frame_tick();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
